// File: rtl/cwt_coeff_fetch.sv
// rtl/cwt_coeff_fetch.sv - wavelet coefficient ROM reader streaming one scale per request
// Credit-limited address issue, two-stage ROM return pipeline and output FIFO.
module cwt_coeff_fetch #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_scale,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [DATA_W-1:0] coef_data,
    output logic [3:0]        coef_idx,
    output logic              coef_last,
    output logic              busy,
    output logic              err_scale
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        issue_q, issue_d;
    logic [3:0]        wr_idx_q, wr_idx_d;
    logic              err_q, err_d;
    logic              v1_q, v2_q;
    logic              issue;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [3:0]        mem_idx_q  [FIFO_DEPTH];
    logic              mem_last_q [FIFO_DEPTH];
    logic              push, pop;
    logic [CNT_W:0]    in_use;
    logic              credit_ok;

    logic [7:0]        tbl_base;
    logic [3:0]        tbl_len;

    always_comb begin
        tbl_base = 8'h00;
        tbl_len  = 4'd8;
        case (req_scale)
            4'd0:    begin tbl_base = 8'h00; tbl_len = 4'd9;  end
            4'd1:    begin tbl_base = 8'h09; tbl_len = 4'd9;  end
            4'd2:    begin tbl_base = 8'h12; tbl_len = 4'd11; end
            4'd3:    begin tbl_base = 8'h1D; tbl_len = 4'd11; end
            4'd4:    begin tbl_base = 8'h28; tbl_len = 4'd9;  end
            4'd5:    begin tbl_base = 8'h31; tbl_len = 4'd9;  end
            4'd6:    begin tbl_base = 8'h3A; tbl_len = 4'd9;  end
            4'd7:    begin tbl_base = 8'h43; tbl_len = 4'd9;  end
            4'd8:    begin tbl_base = 8'h4C; tbl_len = 4'd9;  end
            4'd9:    begin tbl_base = 8'h55; tbl_len = 4'd9;  end
            4'd10:   begin tbl_base = 8'h5E; tbl_len = 4'd8;  end
            4'd11:   begin tbl_base = 8'h66; tbl_len = 4'd8;  end
            4'd12:   begin tbl_base = 8'h6E; tbl_len = 4'd8;  end
            4'd13:   begin tbl_base = 8'h76; tbl_len = 4'd8;  end
            4'd14:   begin tbl_base = 8'h7E; tbl_len = 4'd8;  end
            default: begin tbl_base = 8'h00; tbl_len = 4'd8;  end
        endcase
    end

    assign push       = v2_q;
    assign coef_valid = (count_q != '0);
    assign pop        = coef_valid & coef_ready;
    // Pops in the current cycle are deliberately not credited back to the issue check.
    assign in_use     = {1'b0, count_q} + {{CNT_W{1'b0}}, v1_q} + {{CNT_W{1'b0}}, v2_q};
    assign credit_ok  = (in_use < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        issue_d = issue_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_scale == 4'd15) begin
                        err_d = 1'b1;
                    end else begin
                        // The first address goes out on the acceptance edge itself.
                        base_d  = ADDR_W'(tbl_base);
                        len_d   = tbl_len;
                        addr_d  = ADDR_W'(tbl_base);
                        issue_d = 4'd1;
                        issue   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue   = 1'b1;
                    addr_d  = base_q + ADDR_W'(issue_q);
                    issue_d = issue_q + 4'd1;
                    if (issue_q + 4'd1 == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!v1_q && !v2_q && pop && coef_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_idx_d = wr_idx_q;
        if (state_q == S_IDLE && issue) begin
            wr_idx_d = 4'd0;
        end else if (push) begin
            wr_idx_d = wr_idx_q + 4'd1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            issue_q  <= '0;
            wr_idx_q <= '0;
            err_q    <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issue_q  <= issue_d;
            wr_idx_q <= wr_idx_d;
            err_q    <= err_d;
            v1_q     <= issue;
            v2_q     <= v1_q;
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_idx_q[i]  <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= rom_data;
                mem_idx_q[wr_ptr_q]  <= wr_idx_q;
                mem_last_q[wr_ptr_q] <= (wr_idx_q == len_q - 4'd1);
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (count_q != CNT_W'(FIFO_DEPTH));
        end
    end

    assign rom_addr  = addr_q;
    assign coef_data = mem_data_q[rd_ptr_q];
    assign coef_idx  = mem_idx_q[rd_ptr_q];
    assign coef_last = mem_last_q[rd_ptr_q];
    assign busy      = (state_q != S_IDLE);
    assign req_ready = (state_q == S_IDLE);
    assign err_scale = err_q;

endmodule

// File: tb/tb_cwt_coeff_fetch.sv
// tb/tb_cwt_coeff_fetch.sv - scoreboard bench for cwt_coeff_fetch
module tb_cwt_coeff_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_scale = 4'd0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        coef_valid;
    logic        coef_ready = 1'b1;
    logic [15:0] coef_data;
    logic [3:0]  coef_idx;
    logic        coef_last;
    logic        busy;
    logic        err_scale;

    cwt_coeff_fetch #(.DATA_W(16), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_scale(req_scale),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .coef_idx(coef_idx), .coef_last(coef_last), .busy(busy), .err_scale(err_scale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    logic [15:0] rom [256];
    int          lens [15] = '{9, 9, 11, 11, 9, 9, 9, 9, 9, 9, 8, 8, 8, 8, 8};
    int          n_checks = 0;
    int          n_fail = 0;
    int          hs_count = 0;
    int          last_count = 0;
    int          ready_mode = 0;
    int          cur_base = 0;
    int          cur_len = 0;
    bit          prev_stall = 0, prev_hs = 0, last_pend = 0;
    logic [15:0] pd;
    logic [3:0]  pidx;
    logic        plast;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scale bases are the running sum of the preceding scale lengths.
    function automatic int base_of(input int s);
        int b = 0;
        for (int i = 0; i < s; i++) b += lens[i];
        return b;
    endfunction

    task automatic push_exp(input int s);
        beat_t e;
        cur_base = base_of(s);
        cur_len  = lens[s];
        for (int i = 0; i < lens[s]; i++) begin
            e.d    = rom[cur_base + i];
            e.idx  = 4'(i);
            e.last = (i == lens[s] - 1);
            sb.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            coef_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 0;
            prev_hs    = 0;
            last_pend  = 0;
        end else begin
            if (last_pend) begin
                chk("req_ready_after_last", 32'(req_ready), 32'd1);
                chk("busy_after_last", 32'(busy), 32'd0);
                last_pend = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(coef_valid), 32'd1);
                chk("stall_data", 32'(coef_data), 32'(pd));
                chk("stall_idx", 32'(coef_idx), 32'(pidx));
                chk("stall_last", 32'(coef_last), 32'(plast));
            end
            if (busy) begin
                chk("rom_addr_range",
                    32'((int'(rom_addr) >= cur_base) && (int'(rom_addr) < cur_base + cur_len)), 32'd1);
            end
            if (coef_valid && coef_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", coef_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(coef_data), 32'(e.d));
                    chk("beat_idx", 32'(coef_idx), 32'(e.idx));
                    chk("beat_last", 32'(coef_last), 32'(e.last));
                end
                if (ready_mode == 0 && coef_idx != 4'd0) chk("contiguous", 32'(prev_hs), 32'd1);
                hs_count++;
                if (coef_last) begin
                    last_count++;
                    last_pend = 1;
                end
            end
            prev_hs    = coef_valid && coef_ready;
            prev_stall = coef_valid && !coef_ready;
            pd         = coef_data;
            pidx       = coef_idx;
            plast      = coef_last;
        end
    end

    task automatic do_req(input int s, input bit lat);
        int c = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_scale = 4'(s);
        @(negedge clk);
        while (!req_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("req_accept", 32'(req_ready), 32'd1);
        push_exp(s);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (lat) begin
            @(negedge clk);
            chk("lat_k0_valid", 32'(coef_valid), 32'd0);
            chk("lat_k0_busy", 32'(busy), 32'd1);
            @(negedge clk);
            chk("lat_k1_valid", 32'(coef_valid), 32'd0);
            @(negedge clk);
            chk("lat_k2_valid", 32'(coef_valid), 32'd1);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("drain_complete", 32'(sb.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_coef_valid"}, 32'(coef_valid), 32'd0);
        chk({tag, "_coef_data"}, 32'(coef_data), 32'd0);
        chk({tag, "_coef_idx"}, 32'(coef_idx), 32'd0);
        chk({tag, "_coef_last"}, 32'(coef_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_scale"}, 32'(err_scale), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        int start, c, lc, seen;
        logic [15:0] t1 [9]  = '{16'hFFE4, 16'h011A, 16'hF9EC, 16'h121C, 16'hE2D1,
                                 16'h196C, 16'hF406, 16'h030D, 16'hFF94};
        logic [15:0] t3 [8]  = '{16'h0B6F, 16'hE6F9, 16'h1D9A, 16'hED0F, 16'h068C,
                                 16'hFEC6, 16'h001F, 16'hFFFE};
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 9; i++) rom[i] = t1[i];
        for (int i = 0; i < 8; i++) rom[8'h7E + i] = t3[i];
        rom[8'h12] = 16'h000A; rom[8'h1B] = 16'hFFF0; rom[8'h1C] = 16'h0000;
        rom[8'h5E] = 16'h0076; rom[8'h65] = 16'hFEFA;
        rom[8'h6E] = 16'h01AA; rom[8'h75] = 16'hFFBD;
        rom[8'h76] = 16'h0409; rom[8'h7D] = 16'hFFEE;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk_reset_outputs("reset");

        ready_mode = 0;
        do_req(0, 1'b1);
        wait_idle();
        do_req(2, 1'b0);
        wait_idle();
        ready_mode = 1;
        do_req(14, 1'b0);
        wait_idle();
        ready_mode = 0;

        @(posedge clk);
        #1 req_valid = 1'b1; req_scale = 4'd15;
        @(negedge clk);
        chk("bad_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(err_scale), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("err_single", 32'(err_scale), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (coef_valid || busy) seen = 1;
        end
        chk("err_no_stream", 32'(seen), 32'd0);

        start = hs_count;
        do_req(3, 1'b0);
        c = 0;
        while (hs_count < start + 4 && c < 200) begin
            @(posedge clk);
            c++;
        end
        chk("t5_four_beats", 32'(hs_count - start), 32'd4);
        #1 rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_req_ready", 32'(req_ready), 32'd1);
        do_req(10, 1'b1);
        wait_idle();

        lc = last_count;
        @(posedge clk);
        #1 req_valid = 1'b1; req_scale = 4'd12;
        @(negedge clk);
        chk("t6_first_accept", 32'(req_ready), 32'd1);
        push_exp(12);
        @(posedge clk);
        #1 req_scale = 4'd13;
        c = 0;
        @(negedge clk);
        while (!req_ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("t6_second_accept", 32'(req_ready), 32'd1);
        chk("t6_first_drained", 32'(sb.size()), 32'd0);
        push_exp(13);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_idle();
        chk("t6_last_pulses", 32'(last_count - lc), 32'd2);

        for (int n = 0; n < 12; n++) begin
            ready_mode = int'($urandom_range(0, 1));
            do_req(int'($urandom_range(0, 14)), 1'b0);
            wait_idle();
        end

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
